// File: rtl/irrigation_scheduler.sv
// Purpose : timed irrigation sequencer (fill tank, sprinkle or drip, fertilise every
//           N_AGRO-th sprinkler cycle, flush every N_LIMP-th cycle, latch faults).
// Latency : outputs are registered and change on the same edge as the state.
// Backpressure: none; the inputs are sampled sensor levels and single-cycle pulses.
// Ports:
//   i_clock, i_reset_n        clock and asynchronous active-low reset
//   i_tick                    one-clock time-base pulse
//   i_h / i_l                 tank level high / low
//   i_seco                    soil dry, sampled on the edge that leaves FILL
//   i_start                   manual start, honoured only in IDLE
//   i_e / i_ack               external fault level / error acknowledge pulse
//   o_s_*                     actuator commands and the error lamp
//   o_estado                  state code (IDLE 0, FILL 1, ASP 2, GOT 3, LIMP 4, ERRO 5)
//   o_ciclos                  completed-cycle count, wraps modulo 256
module irrigation_scheduler #(
  parameter int INTERVALO = 8,
  parameter int T_ENCHE   = 10,
  parameter int DUR_ASP   = 4,
  parameter int DUR_GOT   = 8,
  parameter int N_AGRO    = 3,
  parameter int N_LIMP    = 4,
  parameter int DUR_LIMP  = 2
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_tick,
  input  logic       i_h,
  input  logic       i_l,
  input  logic       i_seco,
  input  logic       i_start,
  input  logic       i_e,
  input  logic       i_ack,
  output logic       o_s_enchendo,
  output logic       o_s_aspersao,
  output logic       o_s_agro,
  output logic       o_s_gotejamento,
  output logic       o_s_limpeza,
  output logic       o_s_erro,
  output logic [2:0] o_estado,
  output logic [7:0] o_ciclos
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_ASP  = 3'd2,
    ST_GOT  = 3'd3,
    ST_LIMP = 3'd4,
    ST_ERRO = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_ciclos;
  logic [7:0]  r_agro;
  logic [7:0]  r_limp;
  logic        r_s_enchendo;
  logic        r_s_aspersao;
  logic        r_s_agro;
  logic        r_s_gotejamento;
  logic        r_s_limpeza;
  logic        r_s_erro;
  logic [2:0]  r_estado;

  state_t      w_next;
  logic [15:0] w_cnt_inc;
  logic [15:0] w_cnt_next;
  logic [7:0]  w_ciclos;
  logic [7:0]  w_agro;
  logic [7:0]  w_limp;
  logic [7:0]  w_limp_inc;
  logic        w_done;

  assign w_cnt_inc  = r_cnt + 16'd1;
  assign w_limp_inc = r_limp + 8'd1;

  always_comb begin
    w_next   = r_state;
    w_ciclos = r_ciclos;
    w_agro   = r_agro;
    w_limp   = r_limp;
    w_done   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Start and the interval tick on the same edge give one FILL entry.
        if (i_start || (i_tick && (w_cnt_inc == 16'(INTERVALO)))) begin
          w_next = ST_FILL;
        end
      end
      ST_FILL: begin
        // A full tank wins over a timeout occurring on the same edge.
        if (i_h) begin
          w_next = i_seco ? ST_ASP : ST_GOT;
        end else if (i_tick && (w_cnt_inc == 16'(T_ENCHE))) begin
          w_next = ST_ERRO;
        end
      end
      ST_ASP: begin
        if (i_l || (i_tick && (w_cnt_inc == 16'(DUR_ASP)))) begin
          w_done = 1'b1;
        end
      end
      ST_GOT: begin
        if (i_l || (i_tick && (w_cnt_inc == 16'(DUR_GOT)))) begin
          w_done = 1'b1;
        end
      end
      ST_LIMP: begin
        if (i_tick && (w_cnt_inc == 16'(DUR_LIMP))) begin
          w_next = ST_IDLE;
        end
      end
      ST_ERRO: begin
        if (i_ack && !i_e) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase

    // Cycle completion: bookkeeping plus the choice between flush and idle.
    if (w_done) begin
      w_ciclos = r_ciclos + 8'd1;
      if (r_state == ST_ASP) begin
        w_agro = (r_agro == 8'(N_AGRO - 1)) ? 8'd0 : r_agro + 8'd1;
      end
      if (w_limp_inc == 8'(N_LIMP)) begin
        w_next = ST_LIMP;
        w_limp = 8'd0;
      end else begin
        w_next = ST_IDLE;
        w_limp = w_limp_inc;
      end
    end

    // External fault overrides everything, including a cycle that would complete now.
    if (i_e) begin
      w_next   = ST_ERRO;
      w_ciclos = r_ciclos;
      w_agro   = r_agro;
      w_limp   = r_limp;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_next != r_state) begin
      w_cnt_next = 16'd0;
    end else if (i_tick) begin
      w_cnt_next = w_cnt_inc;
    end
  end

  // State, counters and outputs share one register stage; outputs are decoded
  // from the next state so they switch on the same edge as the state.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= 16'd0;
      r_ciclos        <= 8'd0;
      r_agro          <= 8'd0;
      r_limp          <= 8'd0;
      r_s_enchendo    <= 1'b0;
      r_s_aspersao    <= 1'b0;
      r_s_agro        <= 1'b0;
      r_s_gotejamento <= 1'b0;
      r_s_limpeza     <= 1'b0;
      r_s_erro        <= 1'b0;
      r_estado        <= 3'd0;
    end else begin
      r_state         <= w_next;
      r_cnt           <= w_cnt_next;
      r_ciclos        <= w_ciclos;
      r_agro          <= w_agro;
      r_limp          <= w_limp;
      r_s_enchendo    <= (w_next == ST_FILL);
      r_s_aspersao    <= (w_next == ST_ASP);
      // Entering ASP never changes the agro counter, so w_agro is the running value.
      r_s_agro        <= (w_next == ST_ASP) && (w_agro == 8'(N_AGRO - 1));
      r_s_gotejamento <= (w_next == ST_GOT);
      r_s_limpeza     <= (w_next == ST_LIMP);
      r_s_erro        <= (w_next == ST_ERRO);
      r_estado        <= w_next;
    end
  end

  assign o_s_enchendo    = r_s_enchendo;
  assign o_s_aspersao    = r_s_aspersao;
  assign o_s_agro        = r_s_agro;
  assign o_s_gotejamento = r_s_gotejamento;
  assign o_s_limpeza     = r_s_limpeza;
  assign o_s_erro        = r_s_erro;
  assign o_estado        = r_estado;
  assign o_ciclos        = r_ciclos;

endmodule
